// File: rtl/stage3_ex_pkg.sv
// stage3_ex_pkg: shared types, bus widths, opcode bit positions and store-lane
// helpers for the EX stage (stage3_ex) and its iterative divider (iter_div).
//   ds_to_es_t          : decoded instruction bus from ID (WIDTH_DS_TO_ES_BUS bits)
//   WIDTH_ES_TO_MS_BUS  : 173-bit bus toward MEM
//   WIDTH_ES_TO_DS_BUS  : 41-bit forwarding/stall bus back to ID
//   div_state_t         : DIV_IDLE / DIV_CALC / DIV_DONE
package stage3_ex_pkg;

  localparam int WIDTH_ES_TO_MS_BUS = 173;
  localparam int WIDTH_ES_TO_DS_BUS = 41;

  // div_op is {div.w, mod.w, div.wu, mod.wu}
  localparam int DIV_W  = 3;
  localparam int MOD_W  = 2;
  localparam int DIV_WU = 1;
  localparam int MOD_WU = 0;

  // st_op is {st.w, st.h, st.b}
  localparam int ST_W = 2;
  localparam int ST_H = 1;
  localparam int ST_B = 0;

  // one-hot alu_op bit positions
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // ID->EX bus. For div ops alu_src1/alu_src2 carry rj/rk; rkd is the
  // store data / csr write value.
  typedef struct packed {
    logic [31:0] pc;
    logic [11:0] alu_op;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [31:0] rkd;
    logic        gr_we;
    logic        res_from_mem;
    logic [4:0]  dest;
    logic [2:0]  ld_op;
    logic [2:0]  st_op;
    logic [3:0]  div_op;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic        csr_write;
    logic        ertn;
    logic        csr;
    logic        ex_syscall;
    logic [14:0] code;
  } ds_to_es_t;

  localparam int WIDTH_DS_TO_ES_BUS = $bits(ds_to_es_t);

  // Byte enables for a store; halfword lanes follow addr[1] only, so a
  // misaligned st.h/st.w simply uses the aligned lanes.
  function automatic logic [3:0] st_lane_we(input logic [2:0] st_op,
                                            input logic [1:0] addr);
    logic [3:0] we;
    we = 4'b0000;
    if (st_op[ST_W]) begin
      we = 4'b1111;
    end else if (st_op[ST_H]) begin
      we = 4'b0011 << {addr[1], 1'b0};
    end else if (st_op[ST_B]) begin
      we = 4'b0001 << addr;
    end else begin
      we = 4'b0000;
    end
    return we;
  endfunction

  // Store data replicated over every lane the access could land on.
  function automatic logic [31:0] st_lane_wdata(input logic [2:0] st_op,
                                                input logic [31:0] rkd);
    logic [31:0] wd;
    wd = 32'd0;
    if (st_op[ST_W]) begin
      wd = rkd;
    end else if (st_op[ST_H]) begin
      wd = {2{rkd[15:0]}};
    end else begin
      wd = {4{rkd[7:0]}};
    end
    return wd;
  endfunction

endpackage

// File: rtl/stage3_ex_iter_div.sv
// iter_div: iterative restoring 32-bit divider, one quotient bit per cycle.
// Ports:
//   clk, reset (async, active-high), flush (forces IDLE)
//   start     : begin a division when IDLE
//   signed_op : operands are two's complement
//   a, b      : dividend, divisor
//   ack       : consumer took the result; DONE -> IDLE
//   done      : result valid (state DONE)
//   q, r      : sign-corrected quotient and remainder
// Divide by zero falls out of the algorithm: every trial subtract succeeds,
// giving an all-ones quotient and a remainder equal to the dividend.
module iter_div
  import stage3_ex_pkg::*;
#(
  parameter int DIV_STEPS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ack,
  output logic        done,
  output logic [31:0] q,
  output logic [31:0] r
);

  localparam logic [5:0] LAST_CNT = 6'(DIV_STEPS - 1);

  div_state_t  state_r;
  logic [5:0]  cnt_r;
  logic [31:0] quo_r;
  logic [31:0] rem_r;
  logic [31:0] dvsr_r;
  logic        q_sign_r;
  logic        r_sign_r;

  logic [31:0] a_abs_s;
  logic [31:0] b_abs_s;
  logic [32:0] rem_shift_s;
  logic [31:0] diff_s;
  logic        ge_s;

  // Operand magnitudes and one restoring trial-subtract step
  always_comb begin
    a_abs_s     = (signed_op & a[31]) ? (32'd0 - a) : a;
    b_abs_s     = (signed_op & b[31]) ? (32'd0 - b) : b;
    rem_shift_s = {rem_r, quo_r[31]};
    ge_s        = (rem_shift_s >= {1'b0, dvsr_r});
    // when ge_s holds the true difference fits in 32 bits
    diff_s      = rem_shift_s[31:0] - dvsr_r;
  end

  // Divider FSM and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= DIV_IDLE;
      cnt_r    <= 6'd0;
      quo_r    <= 32'd0;
      rem_r    <= 32'd0;
      dvsr_r   <= 32'd0;
      q_sign_r <= 1'b0;
      r_sign_r <= 1'b0;
    end else if (flush) begin
      state_r <= DIV_IDLE;
      cnt_r   <= 6'd0;
    end else begin
      case (state_r)
        DIV_IDLE: begin
          if (start) begin
            quo_r    <= a_abs_s;
            rem_r    <= 32'd0;
            dvsr_r   <= b_abs_s;
            q_sign_r <= signed_op & (a[31] ^ b[31]);
            r_sign_r <= signed_op & a[31];
            cnt_r    <= 6'd0;
            state_r  <= DIV_CALC;
          end else begin
            state_r <= DIV_IDLE;
          end
        end
        DIV_CALC: begin
          rem_r <= ge_s ? diff_s : rem_shift_s[31:0];
          quo_r <= {quo_r[30:0], ge_s};
          cnt_r <= cnt_r + 6'd1;
          if (cnt_r == LAST_CNT) begin
            state_r <= DIV_DONE;
          end else begin
            state_r <= DIV_CALC;
          end
        end
        DIV_DONE: begin
          if (ack) begin
            state_r <= DIV_IDLE;
          end else begin
            state_r <= DIV_DONE;
          end
        end
        default: begin
          state_r <= DIV_IDLE;
        end
      endcase
    end
  end

  // Sign correction of the unsigned result
  always_comb begin
    done = (state_r == DIV_DONE);
    q    = q_sign_r ? (32'd0 - quo_r) : quo_r;
    r    = r_sign_r ? (32'd0 - rem_r) : rem_r;
  end

endmodule

// File: rtl/stage3_ex.sv
// stage3_ex: execute stage of the 5-stage LoongArch pipeline (ID -> EX -> MEM).
// Latches ds_to_es_bus, runs the inline ALU and the iterative divider, issues
// the data SRAM request and builds the MEM and ID-forwarding buses.
// Ports:
//   clk, reset (async, active-high)
//   ertn_flush, has_int, wb_ex : flush requests (ORed)
//   ds_to_es_valid, ds_to_es_bus, es_allow_in : ID handshake
//   ms_allow_in, es_to_ms_valid, es_to_ms_bus : MEM handshake (173-bit bus)
//   es_to_ds_bus  : {gr_we, dest, result, res_from_mem, csr, busy}
//   if_ms_has_int : MEM holds an exception, suppress this store's byte enables
//   data_sram_en/we/addr/wdata : data SRAM request
// Optional build macro EX_DIV_STALL_CNT_EN adds output div_stall_cnt[31:0],
// a free-running count of cycles EX holds a valid but unfinished instruction.
module stage3_ex
  import stage3_ex_pkg::*;
#(
  parameter int DIV_STEPS = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ertn_flush,
  input  logic                          has_int,
  input  logic                          wb_ex,
  input  logic                          ds_to_es_valid,
  output logic                          es_allow_in,
  input  logic [WIDTH_DS_TO_ES_BUS-1:0] ds_to_es_bus,
  input  logic                          ms_allow_in,
  output logic                          es_to_ms_valid,
  output logic [WIDTH_ES_TO_MS_BUS-1:0] es_to_ms_bus,
  output logic [WIDTH_ES_TO_DS_BUS-1:0] es_to_ds_bus,
  input  logic                          if_ms_has_int,
  output logic                          data_sram_en,
  output logic [3:0]                    data_sram_we,
  output logic [31:0]                   data_sram_addr,
  output logic [31:0]                   data_sram_wdata
`ifdef EX_DIV_STALL_CNT_EN
  ,
  output logic [31:0]                   div_stall_cnt
`endif
);

  logic      es_valid_r;
  ds_to_es_t es_bus_r;

  logic        flush_s;
  logic        is_div_s;
  logic        div_done_s;
  logic        es_ready_go_s;
  logic        es_load_s;
  logic        es_store_s;
  logic        div_busy_s;
  logic [31:0] div_q_s;
  logic [31:0] div_r_s;
  logic [31:0] alu_result_s;
  logic [31:0] sra_res_s;
  logic [31:0] es_result_s;

  assign flush_s       = ertn_flush | has_int | wb_ex;
  assign is_div_s      = |es_bus_r.div_op;
  assign es_ready_go_s = ~is_div_s | div_done_s;
  assign es_allow_in   = ~es_valid_r | (es_ready_go_s & ms_allow_in);
  assign es_load_s     = |es_bus_r.ld_op;
  assign es_store_s    = |es_bus_r.st_op;
  assign div_busy_s    = es_valid_r & is_div_s & ~es_ready_go_s;

  // Valid bit: flush drops the instruction, otherwise follow ID when allowed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      es_valid_r <= 1'b0;
    end else if (flush_s) begin
      es_valid_r <= 1'b0;
    end else if (es_allow_in) begin
      es_valid_r <= ds_to_es_valid;
    end else begin
      es_valid_r <= es_valid_r;
    end
  end

  // Instruction bus register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      es_bus_r <= '0;
    end else if (ds_to_es_valid & es_allow_in) begin
      es_bus_r <= ds_to_es_bus;
    end else begin
      es_bus_r <= es_bus_r;
    end
  end

  iter_div #(
    .DIV_STEPS(DIV_STEPS)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush_s),
    .start    (es_valid_r & is_div_s & ~flush_s),
    .signed_op(es_bus_r.div_op[DIV_W] | es_bus_r.div_op[MOD_W]),
    .a        (es_bus_r.alu_src1),
    .b        (es_bus_r.alu_src2),
    .ack      (ms_allow_in),
    .done     (div_done_s),
    .q        (div_q_s),
    .r        (div_r_s)
  );

  // ALU: one-hot op select, every lane masked then ORed
  always_comb begin
    sra_res_s    = 32'($signed(es_bus_r.alu_src1) >>> es_bus_r.alu_src2[4:0]);
    alu_result_s =
        ({32{es_bus_r.alu_op[ALU_ADD]}}  & (es_bus_r.alu_src1 + es_bus_r.alu_src2))
      | ({32{es_bus_r.alu_op[ALU_SUB]}}  & (es_bus_r.alu_src1 - es_bus_r.alu_src2))
      | ({32{es_bus_r.alu_op[ALU_SLT]}}  &
         {31'd0, $signed(es_bus_r.alu_src1) < $signed(es_bus_r.alu_src2)})
      | ({32{es_bus_r.alu_op[ALU_SLTU]}} & {31'd0, es_bus_r.alu_src1 < es_bus_r.alu_src2})
      | ({32{es_bus_r.alu_op[ALU_AND]}}  & (es_bus_r.alu_src1 & es_bus_r.alu_src2))
      | ({32{es_bus_r.alu_op[ALU_NOR]}}  & ~(es_bus_r.alu_src1 | es_bus_r.alu_src2))
      | ({32{es_bus_r.alu_op[ALU_OR]}}   & (es_bus_r.alu_src1 | es_bus_r.alu_src2))
      | ({32{es_bus_r.alu_op[ALU_XOR]}}  & (es_bus_r.alu_src1 ^ es_bus_r.alu_src2))
      | ({32{es_bus_r.alu_op[ALU_SLL]}}  & (es_bus_r.alu_src1 << es_bus_r.alu_src2[4:0]))
      | ({32{es_bus_r.alu_op[ALU_SRL]}}  & (es_bus_r.alu_src1 >> es_bus_r.alu_src2[4:0]))
      | ({32{es_bus_r.alu_op[ALU_SRA]}}  & sra_res_s)
      | ({32{es_bus_r.alu_op[ALU_LUI]}}  & es_bus_r.alu_src2);
  end

  // Final result: divider output for div ops, mod variants pick the remainder
  always_comb begin
    if (is_div_s) begin
      if (es_bus_r.div_op[MOD_W] | es_bus_r.div_op[MOD_WU]) begin
        es_result_s = div_r_s;
      end else begin
        es_result_s = div_q_s;
      end
    end else begin
      es_result_s = alu_result_s;
    end
  end

  assign es_to_ms_valid = es_valid_r & es_ready_go_s & ~flush_s;

  assign es_to_ms_bus = {es_bus_r.code,          // [172:158]
                         es_bus_r.ex_syscall,    // [157]
                         es_bus_r.rkd,           // [156:125] csr_wvalue
                         es_bus_r.csr,           // [124]
                         es_bus_r.ertn,          // [123]
                         es_bus_r.csr_write,     // [122]
                         es_bus_r.csr_wmask,     // [121:90]
                         es_bus_r.csr_num,       // [89:76]
                         es_bus_r.ld_op,         // [75:73]
                         alu_result_s[1:0],      // [72:71]
                         es_result_s,            // [70:39]
                         es_bus_r.dest,          // [38:34]
                         es_bus_r.res_from_mem,  // [33]
                         es_bus_r.gr_we,         // [32]
                         es_bus_r.pc};           // [31:0]

  assign es_to_ds_bus = {es_valid_r & es_bus_r.gr_we,
                         es_bus_r.dest,
                         es_result_s,
                         es_valid_r & es_bus_r.res_from_mem,
                         es_valid_r & es_bus_r.csr,
                         div_busy_s};

  // Data SRAM request; the access still goes out under if_ms_has_int but
  // writes nothing, so the instruction can flow on to MEM
  always_comb begin
    data_sram_en    = es_valid_r & (es_load_s | es_store_s) & ~flush_s;
    data_sram_addr  = alu_result_s;
    data_sram_wdata = st_lane_wdata(es_bus_r.st_op, es_bus_r.rkd);
    if (if_ms_has_int | es_bus_r.ex_syscall | es_bus_r.ertn | flush_s) begin
      data_sram_we = 4'b0000;
    end else if (es_valid_r & es_store_s) begin
      data_sram_we = st_lane_we(es_bus_r.st_op, alu_result_s[1:0]);
    end else begin
      data_sram_we = 4'b0000;
    end
  end

`ifdef EX_DIV_STALL_CNT_EN
  // Stall cycle counter: wraps naturally, flush does not clear it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_stall_cnt <= 32'd0;
    end else if (es_valid_r & ~es_ready_go_s) begin
      div_stall_cnt <= div_stall_cnt + 32'd1;
    end else begin
      div_stall_cnt <= div_stall_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_stage3_ex.sv
// tb_stage3_ex: directed, table-driven bench for stage3_ex (default build).
module tb_stage3_ex;
  import stage3_ex_pkg::*;

  logic         clk;
  logic         reset;
  logic         ertn_flush, has_int, wb_ex;
  logic         ds_to_es_valid;
  logic         es_allow_in;
  logic [WIDTH_DS_TO_ES_BUS-1:0] ds_to_es_bus;
  logic         ms_allow_in;
  logic         es_to_ms_valid;
  logic [172:0] es_to_ms_bus;
  logic [40:0]  es_to_ds_bus;
  logic         if_ms_has_int;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  int checks = 0;
  int errors = 0;

  stage3_ex dut (
    .clk            (clk),
    .reset          (reset),
    .ertn_flush     (ertn_flush),
    .has_int        (has_int),
    .wb_ex          (wb_ex),
    .ds_to_es_valid (ds_to_es_valid),
    .es_allow_in    (es_allow_in),
    .ds_to_es_bus   (ds_to_es_bus),
    .ms_allow_in    (ms_allow_in),
    .es_to_ms_valid (es_to_ms_valid),
    .es_to_ms_bus   (es_to_ms_bus),
    .es_to_ds_bus   (es_to_ds_bus),
    .if_ms_has_int  (if_ms_has_int),
    .data_sram_en   (data_sram_en),
    .data_sram_we   (data_sram_we),
    .data_sram_addr (data_sram_addr),
    .data_sram_wdata(data_sram_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, want finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  function automatic ds_to_es_t mk_bus(input logic [11:0] op, input logic [31:0] s1,
                                       input logic [31:0] s2, input logic [31:0] rkd,
                                       input logic [2:0] ld, input logic [2:0] st,
                                       input logic [3:0] dv, input logic [31:0] pc);
    ds_to_es_t b;
    b              = '0;
    b.pc           = pc;
    b.alu_op       = op;
    b.alu_src1     = s1;
    b.alu_src2     = s2;
    b.rkd          = rkd;
    b.ld_op        = ld;
    b.st_op        = st;
    b.div_op       = dv;
    b.gr_we        = (st == 3'd0);
    b.res_from_mem = |ld;
    b.dest         = 5'd4;
    return b;
  endfunction

  typedef struct {
    logic [11:0] op;
    logic [31:0] s1, s2, rkd;
    logic [2:0]  ld, st;
    logic        ms_int, fl;
    logic [31:0] exp_res;
    logic        exp_valid, exp_en;
    logic [3:0]  exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic run_div(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    int   n;
    logic busy_ok;
    ds_to_es_bus   = mk_bus(12'h000, a, b, 32'd0, 3'd0, 3'd0, op, 32'h1c00_1000);
    ds_to_es_valid = 1'b1;
    @(negedge clk);
    ds_to_es_valid = 1'b0;
    #1;
    n       = 1;
    busy_ok = 1'b1;
    while (!es_to_ms_valid && n < 40) begin
      if (es_to_ds_bus[0] !== 1'b1 || es_allow_in !== 1'b0) busy_ok = 1'b0;
      @(negedge clk);
      #1;
      n++;
    end
    chk({name, "_cycles"}, n, 32'd34);
    chk({name, "_busy_stall"}, {31'd0, busy_ok}, 32'd1);
    chk({name, "_result"}, es_to_ms_bus[70:39], exp);
    chk({name, "_busy_done"}, {31'd0, es_to_ds_bus[0]}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    // op, s1, s2, rkd, ld, st, ms_int, fl, exp_res, valid, en, we, wdata
    vecs[0]  = '{12'h001, 32'd5, 32'd7, 32'd0, 3'd0, 3'd0, 1'b0, 1'b0, 32'd12, 1'b1, 1'b0, 4'h0, 32'h0};
    vecs[1]  = '{12'h002, 32'd3, 32'd5, 32'd0, 3'd0, 3'd0, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 4'h0, 32'h0};
    vecs[2]  = '{12'h004, 32'hFFFF_FFFF, 32'd1, 32'd0, 3'd0, 3'd0, 1'b0, 1'b0, 32'd1, 1'b1, 1'b0, 4'h0, 32'h0};
    vecs[3]  = '{12'h008, 32'hFFFF_FFFF, 32'd1, 32'd0, 3'd0, 3'd0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 4'h0, 32'h0};
    vecs[4]  = '{12'h010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 3'd0, 3'd0, 1'b0, 1'b0, 32'h00F0_00F0, 1'b1, 1'b0, 4'h0, 32'h0};
    vecs[5]  = '{12'h020, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'd0, 3'd0, 3'd0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0};
    vecs[6]  = '{12'h040, 32'h1234_0000, 32'h0000_5678, 32'd0, 3'd0, 3'd0, 1'b0, 1'b0, 32'h1234_5678, 1'b1, 1'b0, 4'h0, 32'h0};
    vecs[7]  = '{12'h080, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'd0, 3'd0, 3'd0, 1'b0, 1'b0, 32'hF0F0_0F0F, 1'b1, 1'b0, 4'h0, 32'h0};
    vecs[8]  = '{12'h100, 32'd1, 32'd31, 32'd0, 3'd0, 3'd0, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 4'h0, 32'h0};
    vecs[9]  = '{12'h200, 32'h8000_0000, 32'd4, 32'd0, 3'd0, 3'd0, 1'b0, 1'b0, 32'h0800_0000, 1'b1, 1'b0, 4'h0, 32'h0};
    vecs[10] = '{12'h400, 32'h8000_0000, 32'd4, 32'd0, 3'd0, 3'd0, 1'b0, 1'b0, 32'hF800_0000, 1'b1, 1'b0, 4'h0, 32'h0};
    vecs[11] = '{12'h800, 32'd0, 32'hABCD_E000, 32'd0, 3'd0, 3'd0, 1'b0, 1'b0, 32'hABCD_E000, 1'b1, 1'b0, 4'h0, 32'h0};
    vecs[12] = '{12'h001, 32'h1000, 32'd3, 32'h0000_00A5, 3'd0, 3'b001, 1'b0, 1'b0, 32'h1003, 1'b1, 1'b1, 4'b1000, 32'hA5A5_A5A5};
    vecs[13] = '{12'h001, 32'h1000, 32'd2, 32'h1234_BEEF, 3'd0, 3'b010, 1'b0, 1'b0, 32'h1002, 1'b1, 1'b1, 4'b1100, 32'hBEEF_BEEF};
    vecs[14] = '{12'h001, 32'h1000, 32'd4, 32'hDEAD_BEEF, 3'd0, 3'b100, 1'b0, 1'b0, 32'h1004, 1'b1, 1'b1, 4'b1111, 32'hDEAD_BEEF};
    vecs[15] = '{12'h001, 32'h2000, 32'd0, 32'h1122_3344, 3'd0, 3'b100, 1'b1, 1'b0, 32'h2000, 1'b1, 1'b1, 4'b0000, 32'h1122_3344};
    vecs[16] = '{12'h001, 32'h2000, 32'd8, 32'd0, 3'b001, 3'd0, 1'b0, 1'b0, 32'h2008, 1'b1, 1'b1, 4'b0000, 32'h0};
    vecs[17] = '{12'h001, 32'h1000, 32'd1, 32'h0000_005A, 3'd0, 3'b001, 1'b0, 1'b0, 32'h1001, 1'b1, 1'b1, 4'b0010, 32'h5A5A_5A5A};
    vecs[18] = '{12'h001, 32'h3000, 32'd0, 32'hCAFE_F00D, 3'd0, 3'b100, 1'b0, 1'b1, 32'h3000, 1'b0, 1'b0, 4'b0000, 32'hCAFE_F00D};
    vecs[19] = '{12'h001, 32'h1000, 32'd0, 32'h0000_ABCD, 3'd0, 3'b010, 1'b0, 1'b0, 32'h1000, 1'b1, 1'b1, 4'b0011, 32'hABCD_ABCD};

    reset          = 1'b1;
    ertn_flush     = 1'b0;
    has_int        = 1'b0;
    wb_ex          = 1'b0;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus   = '0;
    ms_allow_in    = 1'b1;
    if_ms_has_int  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_es_to_ms_valid", {31'd0, es_to_ms_valid}, 32'd0);
    chk("rst_es_allow_in", {31'd0, es_allow_in}, 32'd1);
    chk("rst_sram_en", {31'd0, data_sram_en}, 32'd0);
    chk("rst_sram_we", {28'd0, data_sram_we}, 32'd0);
    chk("rst_fsm", 32'(dut.u_div.state_r), 32'(DIV_IDLE));
    @(negedge clk);
    reset = 1'b0;

    // Single-cycle ALU / load / store vectors
    for (int i = 0; i < NV; i++) begin
      ds_to_es_bus   = mk_bus(vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].rkd,
                              vecs[i].ld, vecs[i].st, 4'd0, 32'h1c00_0000 + 32'(i * 4));
      ds_to_es_valid = 1'b1;
      if_ms_has_int  = 1'b0;
      has_int        = 1'b0;
      @(negedge clk);
      ds_to_es_valid = 1'b0;
      if_ms_has_int  = vecs[i].ms_int;
      has_int        = vecs[i].fl;
      #1;
      chk($sformatf("v%0d_valid", i), {31'd0, es_to_ms_valid}, {31'd0, vecs[i].exp_valid});
      chk($sformatf("v%0d_result", i), es_to_ms_bus[70:39], vecs[i].exp_res);
      chk($sformatf("v%0d_addr", i), data_sram_addr, vecs[i].exp_res);
      chk($sformatf("v%0d_en", i), {31'd0, data_sram_en}, {31'd0, vecs[i].exp_en});
      chk($sformatf("v%0d_we", i), {28'd0, data_sram_we}, {28'd0, vecs[i].exp_we});
      chk($sformatf("v%0d_pc", i), es_to_ms_bus[31:0], 32'h1c00_0000 + 32'(i * 4));
      chk($sformatf("v%0d_busy", i), {31'd0, es_to_ds_bus[0]}, 32'd0);
      chk($sformatf("v%0d_addr_lo", i), {30'd0, es_to_ms_bus[72:71]}, {30'd0, vecs[i].exp_res[1:0]});
      if (vecs[i].st != 3'd0) begin
        chk($sformatf("v%0d_wdata", i), data_sram_wdata, vecs[i].exp_wdata);
      end
    end
    if_ms_has_int = 1'b0;
    has_int       = 1'b0;
    @(negedge clk);

    // Divider: signs, overflow case, divide by zero
    run_div("div_w_m7_2",    4'b1000, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_div("mod_w_m7_2",    4'b0100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_div("div_w_ovf",     4'b1000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_div("mod_w_ovf",     4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_div("div_wu_5_0",    4'b0010, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_div("mod_wu_5_0",    4'b0001, 32'd5, 32'd0, 32'd5);
    run_div("div_wu_100_7",  4'b0010, 32'd100, 32'd7, 32'd14);
    run_div("mod_wu_100_7",  4'b0001, 32'd100, 32'd7, 32'd2);

    // wb_ex in DONE while MEM stalls: nothing handed on, divider back to IDLE
    ms_allow_in    = 1'b0;
    ds_to_es_bus   = mk_bus(12'h000, 32'd40, 32'd4, 32'd0, 3'd0, 3'd0, 4'b1000, 32'h1c00_2000);
    ds_to_es_valid = 1'b1;
    @(negedge clk);
    ds_to_es_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (dut.u_div.state_r != DIV_DONE && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("flush_reach_done", {31'd0, (n < 40)}, 32'd1);
    end
    #1;
    chk("flush_pre_valid", {31'd0, es_to_ms_valid}, 32'd1);
    chk("flush_pre_allow", {31'd0, es_allow_in}, 32'd0);
    wb_ex = 1'b1;
    #1;
    chk("flush_valid_comb", {31'd0, es_to_ms_valid}, 32'd0);
    chk("flush_sram_en", {31'd0, data_sram_en}, 32'd0);
    @(negedge clk);
    wb_ex       = 1'b0;
    ms_allow_in = 1'b1;
    #1;
    chk("flush_fsm_idle", 32'(dut.u_div.state_r), 32'(DIV_IDLE));
    chk("flush_valid_after", {31'd0, es_to_ms_valid}, 32'd0);
    chk("flush_allow_after", {31'd0, es_allow_in}, 32'd1);
    ds_to_es_bus   = mk_bus(12'h001, 32'd20, 32'd22, 32'd0, 3'd0, 3'd0, 4'd0, 32'h1c00_2004);
    ds_to_es_valid = 1'b1;
    @(negedge clk);
    ds_to_es_valid = 1'b0;
    #1;
    chk("post_flush_add_valid", {31'd0, es_to_ms_valid}, 32'd1);
    chk("post_flush_add_result", es_to_ms_bus[70:39], 32'd42);
    @(negedge clk);

    // Reset in the middle of a division
    ds_to_es_bus   = mk_bus(12'h000, 32'd1000, 32'd3, 32'd0, 3'd0, 3'd0, 4'b1000, 32'h1c00_3000);
    ds_to_es_valid = 1'b1;
    @(negedge clk);
    ds_to_es_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (!(dut.u_div.state_r == DIV_CALC && dut.u_div.cnt_r == 6'd10) && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("rst_mid_reach_cnt10", {31'd0, (n < 40)}, 32'd1);
    end
    reset = 1'b1;
    #1;
    chk("rst_mid_es_valid", {31'd0, dut.es_valid_r}, 32'd0);
    chk("rst_mid_fsm", 32'(dut.u_div.state_r), 32'(DIV_IDLE));
    chk("rst_mid_es_to_ms_valid", {31'd0, es_to_ms_valid}, 32'd0);
    chk("rst_mid_allow", {31'd0, es_allow_in}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
